// File: rtl/enc_chk_pkg.sv
// Shared definitions for the 20G encoder check-path run controller:
// FSM state encoding and default generator/drain constants.
package enc_chk_pkg;

  localparam int unsigned ST_WD = 3;

  typedef enum logic [ST_WD-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SEND  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_LATCH = 3'd5
  } state_e;

  localparam logic [47:0]  PAD_DEF       = 48'hBBBBCCCCDDDD;
  localparam int unsigned  DRAIN_CYC_DEF = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr_20g_enc_chk_ctrl.sv
// Run controller: clears the checker, streams an indexed word sequence into it,
// drains, then latches the checker counts and a pass/fail verdict.
module ddr_20g_enc_chk_ctrl
  import enc_chk_pkg::*;
#(
  parameter int unsigned DATA_WD   = 64,
  parameter int unsigned LEN_WD    = 32,
  parameter int unsigned GAP_WD    = 8,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
  parameter logic [47:0] PAD       = PAD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [LEN_WD-1:0]  cfg_len,
  input  logic [GAP_WD-1:0]  cfg_gap,
  input  logic               cfg_inj_en,
  input  logic [LEN_WD-1:0]  cfg_inj_idx,
  output logic               chk_rst,
  output logic               gen_vld,
  output logic [DATA_WD-1:0] gen_data,
  input  logic [31:0]        suc_cnt,
  input  logic [31:0]        err_cnt,
  output logic               sts_busy,
  output logic               sts_done,
  output logic               sts_pass,
  output logic [31:0]        sts_suc,
  output logic [31:0]        sts_err
);

  localparam int unsigned PAD_WD = DATA_WD - 16;
  localparam int unsigned DRN_WD = $clog2(DRAIN_CYC + 1);
  localparam int unsigned CNT_WD = max_u(GAP_WD, DRN_WD);
  localparam int unsigned CMP_WD = max_u(LEN_WD, 32) + 1;

  state_e              r_state,    w_state_nxt;
  logic [LEN_WD-1:0]   r_len,      w_len_nxt;
  logic [GAP_WD-1:0]   r_gap,      w_gap_nxt;
  logic                r_inj_en,   w_inj_en_nxt;
  logic [LEN_WD-1:0]   r_inj_idx,  w_inj_idx_nxt;
  logic [LEN_WD-1:0]   r_idx,      w_idx_nxt;
  logic [CNT_WD-1:0]   r_cnt,      w_cnt_nxt;
  logic                r_chk_rst,  w_chk_rst_nxt;
  logic                r_gen_vld,  w_gen_vld_nxt;
  logic [DATA_WD-1:0]  r_gen_data, w_gen_data_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_pass,     w_pass_nxt;
  logic [31:0]         r_suc,      w_suc_nxt;
  logic [31:0]         r_err,      w_err_nxt;

  logic                w_inj_hit;
  logic                w_last;
  logic                w_verdict;
  logic [CMP_WD-1:0]   w_suc_ext;
  logic [CMP_WD-1:0]   w_len_ext;

  // Word for index idx: PAD above a 16-bit wrapping index, bit 0 flipped on the injected word.
  function automatic logic [DATA_WD-1:0] f_word(input logic [LEN_WD-1:0] idx,
                                                input logic              inj_en,
                                                input logic [LEN_WD-1:0] inj_idx);
    logic [DATA_WD-1:0] w;
    w    = {PAD_WD'(PAD), 16'(idx)};
    w[0] = w[0] ^ (inj_en && (idx == inj_idx));
    return w;
  endfunction

  assign w_inj_hit = r_inj_en && (r_inj_idx < r_len);
  assign w_last    = (r_idx == (r_len - LEN_WD'(1)));
  assign w_suc_ext = CMP_WD'(suc_cnt);
  assign w_len_ext = CMP_WD'(r_len);

  // With an injected word the checker should see exactly one error and len-1 good words.
  assign w_verdict = w_inj_hit
                   ? ((w_suc_ext == (w_len_ext - CMP_WD'(1))) && (err_cnt == 32'd1))
                   : ((w_suc_ext == w_len_ext) && (err_cnt == 32'd0));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_gap_nxt      = r_gap;
    w_inj_en_nxt   = r_inj_en;
    w_inj_idx_nxt  = r_inj_idx;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_chk_rst_nxt  = 1'b0;
    w_gen_vld_nxt  = 1'b0;
    w_gen_data_nxt = r_gen_data;
    w_done_nxt     = r_done;
    w_pass_nxt     = r_pass;
    w_suc_nxt      = r_suc;
    w_err_nxt      = r_err;

    if (cfg_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_start && !cfg_abort) begin
            w_state_nxt   = ST_CLR;
            w_len_nxt     = cfg_len;
            w_gap_nxt     = cfg_gap;
            w_inj_en_nxt  = cfg_inj_en;
            w_inj_idx_nxt = cfg_inj_idx;
            w_idx_nxt     = '0;
            w_done_nxt    = 1'b0;
            w_pass_nxt    = 1'b0;
            w_chk_rst_nxt = 1'b1;
          end
        end

        ST_CLR: begin
          if (r_len == '0) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = CNT_WD'(DRAIN_CYC);
          end else begin
            w_state_nxt    = ST_SEND;
            w_gen_vld_nxt  = 1'b1;
            w_gen_data_nxt = f_word(r_idx, r_inj_en, r_inj_idx);
          end
        end

        ST_SEND: begin
          w_idx_nxt = r_idx + LEN_WD'(1);
          if (w_last) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = CNT_WD'(DRAIN_CYC);
          end else if (r_gap != '0) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = CNT_WD'(r_gap);
          end else begin
            w_state_nxt    = ST_SEND;
            w_gen_vld_nxt  = 1'b1;
            w_gen_data_nxt = f_word(r_idx + LEN_WD'(1), r_inj_en, r_inj_idx);
          end
        end

        ST_GAP: begin
          if (r_cnt == CNT_WD'(1)) begin
            w_state_nxt    = ST_SEND;
            w_gen_vld_nxt  = 1'b1;
            w_gen_data_nxt = f_word(r_idx, r_inj_en, r_inj_idx);
          end else begin
            w_cnt_nxt = r_cnt - CNT_WD'(1);
          end
        end

        ST_DRAIN: begin
          if (r_cnt == CNT_WD'(1)) begin
            w_state_nxt = ST_LATCH;
          end else begin
            w_cnt_nxt = r_cnt - CNT_WD'(1);
          end
        end

        ST_LATCH: begin
          w_state_nxt = ST_IDLE;
          w_suc_nxt   = suc_cnt;
          w_err_nxt   = err_cnt;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = w_verdict;
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_gap      <= '0;
      r_inj_en   <= 1'b0;
      r_inj_idx  <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_chk_rst  <= 1'b0;
      r_gen_vld  <= 1'b0;
      r_gen_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_suc      <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_gap      <= w_gap_nxt;
      r_inj_en   <= w_inj_en_nxt;
      r_inj_idx  <= w_inj_idx_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_chk_rst  <= w_chk_rst_nxt;
      r_gen_vld  <= w_gen_vld_nxt;
      r_gen_data <= w_gen_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_suc      <= w_suc_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign chk_rst  = r_chk_rst;
  assign gen_vld  = r_gen_vld;
  assign gen_data = r_gen_data;
  assign sts_busy = r_busy;
  assign sts_done = r_done;
  assign sts_pass = r_pass;
  assign sts_suc  = r_suc;
  assign sts_err  = r_err;

endmodule

// File: tb/tb_ddr_20g_enc_chk_ctrl.sv
// Scoreboard bench for ddr_20g_enc_chk_ctrl with a behavioural checker stand-in
// driving suc_cnt/err_cnt and a spec-level model producing expected words and status.
module tb_ddr_20g_enc_chk_ctrl;

  localparam logic [47:0] TB_PAD = 48'hBBBBCCCCDDDD;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } word_t;

  typedef struct {
    int          cyc;
    logic [31:0] suc;
    logic [31:0] err;
    logic        pass;
  } sts_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] cfg_len = '0;
  logic [7:0]  cfg_gap = '0;
  logic        cfg_inj_en = 1'b0;
  logic [31:0] cfg_inj_idx = '0;
  logic        chk_rst;
  logic        gen_vld;
  logic [63:0] gen_data;
  logic [31:0] suc_cnt;
  logic [31:0] err_cnt;
  logic        sts_busy;
  logic        sts_done;
  logic        sts_pass;
  logic [31:0] sts_suc;
  logic [31:0] sts_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  word_t exp_words[$];
  int    exp_rst[$];
  sts_t  exp_sts[$];

  logic        mon_en = 1'b1;
  logic        prev_done = 1'b0;
  logic [31:0] extra_err = '0;
  logic [31:0] last_suc = '0;
  logic [31:0] last_err = '0;

  // Checker stand-in: counts in-sequence words as successes, anything else as errors.
  logic [31:0] m_suc, m_err;
  logic [15:0] m_seq;

  ddr_20g_enc_chk_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_abort   (cfg_abort),
    .cfg_len     (cfg_len),
    .cfg_gap     (cfg_gap),
    .cfg_inj_en  (cfg_inj_en),
    .cfg_inj_idx (cfg_inj_idx),
    .chk_rst     (chk_rst),
    .gen_vld     (gen_vld),
    .gen_data    (gen_data),
    .suc_cnt     (suc_cnt),
    .err_cnt     (err_cnt),
    .sts_busy    (sts_busy),
    .sts_done    (sts_done),
    .sts_pass    (sts_pass),
    .sts_suc     (sts_suc),
    .sts_err     (sts_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_suc <= '0;
      m_err <= '0;
      m_seq <= '0;
    end else if (chk_rst) begin
      m_suc <= '0;
      m_err <= '0;
      m_seq <= '0;
    end else if (gen_vld) begin
      if (gen_data == {TB_PAD, m_seq}) m_suc <= m_suc + 1;
      else                             m_err <= m_err + 1;
      m_seq <= m_seq + 16'd1;
    end
  end

  assign suc_cnt = m_suc;
  assign err_cnt = m_err + extra_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents chk_rst, a word or a new verdict.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (chk_rst) begin
        if (exp_rst.size() == 0) check("unexpected_chk_rst", 64'(cyc), 64'hFFFF_FFFF);
        else check("chk_rst_cyc", 64'(cyc), 64'(exp_rst.pop_front()));
      end
      if (gen_vld) begin
        if (exp_words.size() == 0) begin
          check("unexpected_word", gen_data, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          word_t w;
          w = exp_words.pop_front();
          check("word_data", gen_data, w.data);
          check("word_cyc", 64'(cyc), 64'(w.cyc));
        end
      end
      if (sts_done && !prev_done) begin
        if (exp_sts.size() == 0) begin
          check("unexpected_done", 64'(sts_done), 64'd0);
        end else begin
          sts_t s;
          s = exp_sts.pop_front();
          check("done_cyc", 64'(cyc), 64'(s.cyc));
          check("sts_suc", 64'(sts_suc), 64'(s.suc));
          check("sts_err", 64'(sts_err), 64'(s.err));
          check("sts_pass", 64'(sts_pass), 64'(s.pass));
        end
      end
    end
    prev_done <= sts_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the spec-derived expectations for one run, then pulse cfg_start.
  // n_words < 0: the run completes; otherwise only n_words words are expected (run aborted).
  task automatic run_start(input int len, input int gap, input bit inj, input int idx,
                           input int extra, input int n_words);
    int    c0, n, last;
    bit    hit;
    word_t w;
    sts_t  s;
    c0  = cyc;
    hit = inj && (idx < len);
    n   = (n_words < 0) ? len : n_words;
    exp_rst.push_back(c0 + 1);
    for (int k = 0; k < n; k++) begin
      w.cyc  = c0 + 2 + k * (gap + 1);
      w.data = {TB_PAD, 16'(k)};
      if (hit && k == idx) w.data[0] = ~w.data[0];
      exp_words.push_back(w);
    end
    if (n_words < 0) begin
      last  = c0 + 2 + (len - 1) * (gap + 1);
      s.cyc = (len == 0) ? c0 + 19 : last + 18;
      s.suc = hit ? 32'(len - 1) : 32'(len);
      s.err = (hit ? 32'd1 : 32'd0) + 32'(extra);
      s.pass = (extra == 0);
      exp_sts.push_back(s);
      last_suc = s.suc;
      last_err = s.err;
    end
    extra_err   = 32'(extra);
    cfg_len     = 32'(len);
    cfg_gap     = 8'(gap);
    cfg_inj_en  = inj;
    cfg_inj_idx = 32'(idx);
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sts_busy && n < budget) begin
      tick();
      n++;
    end
    if (sts_busy) check("run_timeout", 64'(sts_busy), 64'd0);
    tick();
  endtask

  task automatic run(input int len, input int gap, input bit inj, input int idx, input int extra);
    run_start(len, gap, inj, idx, extra, -1);
    wait_idle(len * (gap + 1) + 64);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_chk_rst", 64'(chk_rst), 64'd0);
    check("rst_gen_vld", 64'(gen_vld), 64'd0);
    check("rst_gen_data", gen_data, 64'd0);
    check("rst_busy", 64'(sts_busy), 64'd0);
    check("rst_done", 64'(sts_done), 64'd0);
    check("rst_pass", 64'(sts_pass), 64'd0);
    check("rst_suc", 64'(sts_suc), 64'd0);
    check("rst_err", 64'(sts_err), 64'd0);

    // Back-to-back words; a start and new cfg_len mid-run must be ignored.
    run_start(8, 0, 1'b0, 0, 0, -1);
    check("busy_after_start", 64'(sts_busy), 64'd1);
    repeat (3) tick();
    cfg_len   = 32'd3;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_idle(100);

    run(4, 3, 1'b0, 0, 0);
    run(10, 0, 1'b1, 5, 0);
    run(10, 0, 1'b1, 5, 1);
    run(0, 0, 1'b0, 0, 0);
    run(6, 2, 1'b1, 9, 0);

    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 24)), 0);
    end

    // Abort during the third SEND of a 100-word run.
    run_start(100, 0, 1'b0, 0, 0, 3);
    repeat (3) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("abort_vld", 64'(gen_vld), 64'd0);
    check("abort_busy", 64'(sts_busy), 64'd0);
    check("abort_done", 64'(sts_done), 64'd0);
    check("abort_suc_hold", 64'(sts_suc), 64'(last_suc));
    check("abort_err_hold", 64'(sts_err), 64'(last_err));
    repeat (4) tick();
    run(20, 1, 1'b0, 0, 0);

    // Start and abort in the same IDLE cycle: no run.
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    check("start_abort_busy", 64'(sts_busy), 64'd0);
    check("start_abort_chk_rst", 64'(chk_rst), 64'd0);
    tick();
    check("start_abort_vld", 64'(gen_vld), 64'd0);

    // Long run crossing the 16-bit index wrap.
    run(70000, 0, 1'b0, 0, 0);

    // Asynchronous reset in the middle of SEND.
    mon_en = 1'b0;
    run_start(50, 0, 1'b0, 0, 0, 0);
    exp_rst.delete();
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gen_vld", 64'(gen_vld), 64'd0);
    check("arst_gen_data", gen_data, 64'd0);
    check("arst_busy", 64'(sts_busy), 64'd0);
    check("arst_done", 64'(sts_done), 64'd0);
    check("arst_suc", 64'(sts_suc), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    run(3, 0, 1'b0, 0, 0);

    repeat (4) tick();
    check("words_left", 64'(exp_words.size()), 64'd0);
    check("status_left", 64'(exp_sts.size()), 64'd0);
    check("chk_rst_left", 64'(exp_rst.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
